// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router ingress controller.
// Holds the FSM state enum, port count, invalid address and watchdog default.
package router_pkg;

  localparam int         NUM_PORTS    = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int         DEF_TIMEOUT  = 30;

  typedef enum logic [2:0] {
    DECODE,
    WAIT_EMPTY,
    LOAD_FIRST,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL,
    LOAD_AFTER_FULL,
    CHECK_PARITY
  } state_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(
    input logic [1:0] a
  );
    logic [NUM_PORTS-1:0] r;
    r = '0;
    case (a)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_soft_rst_timer.sv
// Idle-read watchdog for one output port: pulses soft_reset_o for one
// cycle after TIMEOUT-1 consecutive cycles of valid, unread data.
// Ports: clk_i, rst_ni (sync, active-low), vld_i, read_enb_i, soft_reset_o.
module router_soft_rst_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vld_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The pulse is a pure function of the count, so it lasts exactly
  // one cycle: the count always returns to zero after reaching LAST.
  assign soft_reset_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (soft_reset_o || !vld_i || read_enb_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/router_ctrl.sv
// Ingress controller for the 1x3 router: header decode, load sequencing,
// backpressure, per-port idle-read watchdogs (macro ROUTER_SOFT_RESET_EN).
// In: clk, rst (sync, active-low), pkt_valid, data_in, fifo_full/empty,
// read_enb, parity_done, low_pkt_valid. Out: busy, write_enb, state
// strobes, vld_out, soft_reset.
module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       abort;
  logic [1:0] hdr_addr;

  assign hdr_addr = data_in[1:0];
  assign vld_out  = ~fifo_empty;

`ifdef ROUTER_SOFT_RESET_EN
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wdt
    router_soft_rst_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_wdt (
      .clk_i       (clk),
      .rst_ni      (rst),
      .vld_i       (vld_out[g]),
      .read_enb_i  (read_enb[g]),
      .soft_reset_o(soft_reset[g])
    );
  end

  // A flush of the port being loaded abandons the packet.
  assign abort = soft_reset[addr_q] && (state_q != DECODE);

  logic unused;
  assign unused = ^data_in[7:2];
`else
  assign soft_reset = '0;
  assign abort      = 1'b0;

  logic unused;
  assign unused = ^{data_in[7:2], read_enb};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      DECODE: begin
        if (pkt_valid && hdr_addr != ADDR_INVALID) begin
          addr_d  = hdr_addr;
          state_d = fifo_empty[hdr_addr] ? LOAD_FIRST : WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        if (fifo_empty[addr_q]) state_d = LOAD_FIRST;
      end
      LOAD_FIRST: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full[addr_q])  state_d = FIFO_FULL;
        else if (!pkt_valid)    state_d = LOAD_PARITY;
      end
      LOAD_PARITY: state_d = CHECK_PARITY;
      CHECK_PARITY: begin
        state_d = fifo_full[addr_q] ? FIFO_FULL : DECODE;
      end
      FIFO_FULL: begin
        if (!fifo_full[addr_q]) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      default: state_d = DECODE;
    endcase
    if (abort) state_d = DECODE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DECODE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add  = (state_q == DECODE);
  assign lfd_state   = (state_q == LOAD_FIRST);
  assign ld_state    = (state_q == LOAD_DATA);
  assign laf_state   = (state_q == LOAD_AFTER_FULL);
  assign full_state  = (state_q == FIFO_FULL);
  assign rst_int_reg = (state_q == CHECK_PARITY);

  assign busy = !((state_q == DECODE) || (state_q == LOAD_DATA));

  always_comb begin
    write_enb = '0;
    if ((state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
        (state_q == LOAD_AFTER_FULL)) begin
      write_enb = port_onehot(addr_q);
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: directed vector table,
// watchdog sequences and randomized traffic against a reference model.
module tb_router_ctrl;

  localparam int TO = 30;
`ifdef ROUTER_SOFT_RESET_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  localparam int S_DEC  = 0;
  localparam int S_WAIT = 1;
  localparam int S_LF   = 2;
  localparam int S_LD   = 3;
  localparam int S_LP   = 4;
  localparam int S_FF   = 5;
  localparam int S_LAF  = 6;
  localparam int S_CP   = 7;

  logic       clk;
  logic       rst;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       busy;
  logic [2:0] write_enb;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  router_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .read_enb     (read_enb),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .busy         (busy),
    .write_enb    (write_enb),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         m_st = S_DEC;
  logic [1:0] m_addr = 2'd0;
  int         m_streak [3] = '{0, 0, 0};

  typedef struct {
    logic       r;
    logic       pv;
    logic [7:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic       pdone;
    logic       lowpv;
    logic       busy;
    logic [2:0] we;
    logic [5:0] str;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(logic r, logic pv, logic [7:0] din,
                              logic [2:0] f, logic [2:0] e,
                              logic pd, logic lp, logic b,
                              logic [2:0] w, logic [5:0] s);
    vec_t v;
    v.r = r; v.pv = pv; v.din = din; v.full = f; v.empty = e;
    v.pdone = pd; v.lowpv = lp; v.busy = b; v.we = w; v.str = s;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] m_soft();
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 3; i++) s[i] = WDT && (m_streak[i] == TO - 1);
    return s;
  endfunction

  // Advance the reference by one clock using the inputs now applied.
  task automatic model_edge();
    logic [2:0] sr;
    int         nst;
    logic [1:0] na;
    sr  = m_soft();
    nst = m_st;
    na  = m_addr;
    if (!rst) begin
      nst = S_DEC;
      na  = 2'd0;
      for (int i = 0; i < 3; i++) m_streak[i] = 0;
    end else begin
      case (m_st)
        S_DEC:
          if (pkt_valid && data_in[1:0] != 2'b11) begin
            na  = data_in[1:0];
            nst = fifo_empty[data_in[1:0]] ? S_LF : S_WAIT;
          end
        S_WAIT: if (fifo_empty[m_addr]) nst = S_LF;
        S_LF:   nst = S_LD;
        S_LD:
          if (fifo_full[m_addr]) nst = S_FF;
          else if (!pkt_valid)   nst = S_LP;
        S_LP:   nst = S_CP;
        S_CP:   nst = fifo_full[m_addr] ? S_FF : S_DEC;
        S_FF:   if (!fifo_full[m_addr]) nst = S_LAF;
        S_LAF:
          nst = parity_done ? S_DEC : (low_pkt_valid ? S_LP : S_LD);
        default: nst = S_DEC;
      endcase
      if (m_st != S_DEC && sr[m_addr]) nst = S_DEC;
      for (int i = 0; i < 3; i++) begin
        if (sr[i] || fifo_empty[i] || read_enb[i]) m_streak[i] = 0;
        else m_streak[i] = m_streak[i] + 1;
      end
    end
    m_st   = nst;
    m_addr = na;
  endtask

  task automatic step_model(string tag);
    logic       eb;
    logic [2:0] ew;
    logic [5:0] es;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    eb = !(m_st == S_DEC || m_st == S_LD);
    ew = (m_st == S_LD || m_st == S_LP || m_st == S_LAF)
         ? (3'b001 << m_addr) : 3'b000;
    es = {m_st == S_DEC, m_st == S_LF, m_st == S_LD,
          m_st == S_LAF, m_st == S_FF, m_st == S_CP};
    check({tag, " busy"}, {7'd0, busy}, {7'd0, eb});
    check({tag, " write_enb"}, {5'd0, write_enb}, {5'd0, ew});
    check({tag, " strobes"},
          {2'd0, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg}, {2'd0, es});
    check({tag, " vld_out"}, {5'd0, vld_out}, {5'd0, ~fifo_empty});
    check({tag, " soft_reset"}, {5'd0, soft_reset}, {5'd0, m_soft()});
  endtask

  localparam logic [5:0] T_DEC = 6'b100000;
  localparam logic [5:0] T_NON = 6'b000000;
  localparam logic [5:0] T_LF  = 6'b010000;
  localparam logic [5:0] T_LD  = 6'b001000;
  localparam logic [5:0] T_LAF = 6'b000100;
  localparam logic [5:0] T_FF  = 6'b000010;
  localparam logic [5:0] T_CP  = 6'b000001;

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b111;
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    tbl[0]  = mk(0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 0, 3'b000, T_DEC);
    tbl[1]  = mk(1, 1, 8'h01, 3'b000, 3'b111, 0, 0, 1, 3'b000, T_LF);
    tbl[2]  = mk(1, 1, 8'h55, 3'b000, 3'b111, 0, 0, 0, 3'b010, T_LD);
    tbl[3]  = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 1, 3'b010, T_NON);
    tbl[4]  = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 1, 3'b000, T_CP);
    tbl[5]  = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 0, 3'b000, T_DEC);
    tbl[6]  = mk(1, 1, 8'h02, 3'b000, 3'b011, 0, 0, 1, 3'b000, T_NON);
    tbl[7]  = mk(1, 1, 8'hAA, 3'b000, 3'b011, 0, 0, 1, 3'b000, T_NON);
    tbl[8]  = mk(1, 1, 8'hAA, 3'b000, 3'b111, 0, 0, 1, 3'b000, T_LF);
    tbl[9]  = mk(1, 1, 8'h00, 3'b000, 3'b111, 0, 0, 0, 3'b100, T_LD);
    tbl[10] = mk(1, 0, 8'h00, 3'b100, 3'b111, 0, 0, 1, 3'b000, T_FF);
    tbl[11] = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 1, 1, 3'b100, T_LAF);
    tbl[12] = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 1, 1, 3'b100, T_NON);
    tbl[13] = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 1, 3'b000, T_CP);
    tbl[14] = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 0, 3'b000, T_DEC);
    tbl[15] = mk(1, 1, 8'h03, 3'b000, 3'b111, 0, 0, 0, 3'b000, T_DEC);
    tbl[16] = mk(1, 1, 8'h00, 3'b000, 3'b111, 0, 0, 1, 3'b000, T_LF);
    tbl[17] = mk(1, 1, 8'h00, 3'b000, 3'b111, 0, 0, 0, 3'b001, T_LD);
    tbl[18] = mk(1, 1, 8'h00, 3'b001, 3'b111, 0, 0, 1, 3'b000, T_FF);
    tbl[19] = mk(1, 1, 8'h00, 3'b001, 3'b111, 0, 0, 1, 3'b000, T_FF);
    tbl[20] = mk(1, 1, 8'h00, 3'b000, 3'b111, 0, 0, 1, 3'b001, T_LAF);
    tbl[21] = mk(1, 1, 8'h00, 3'b000, 3'b111, 0, 0, 0, 3'b001, T_LD);
    tbl[22] = mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 1, 3'b001, T_NON);
    tbl[23] = mk(1, 0, 8'h00, 3'b001, 3'b111, 0, 0, 1, 3'b000, T_CP);
    tbl[24] = mk(1, 0, 8'h00, 3'b001, 3'b111, 0, 0, 1, 3'b000, T_FF);
    tbl[25] = mk(1, 0, 8'h00, 3'b000, 3'b111, 1, 0, 1, 3'b001, T_LAF);
    tbl[26] = mk(1, 0, 8'h00, 3'b000, 3'b111, 1, 0, 0, 3'b000, T_DEC);
    tbl[27] = mk(1, 1, 8'h01, 3'b000, 3'b111, 0, 0, 1, 3'b000, T_LF);
    tbl[28] = mk(0, 1, 8'h01, 3'b000, 3'b111, 0, 0, 0, 3'b000, T_DEC);

    @(negedge clk);

    for (int i = 0; i < 29; i++) begin
      rst = tbl[i].r; pkt_valid = tbl[i].pv; data_in = tbl[i].din;
      fifo_full = tbl[i].full; fifo_empty = tbl[i].empty;
      parity_done = tbl[i].pdone; low_pkt_valid = tbl[i].lowpv;
      read_enb = 3'b111;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d busy", i), {7'd0, busy}, {7'd0, tbl[i].busy});
      check($sformatf("tbl%0d write_enb", i),
            {5'd0, write_enb}, {5'd0, tbl[i].we});
      check($sformatf("tbl%0d strobes", i),
            {2'd0, detect_add, lfd_state, ld_state,
             laf_state, full_state, rst_int_reg}, {2'd0, tbl[i].str});
    end

    // Port 0 holds unread data; a header to port 0 parks in WAIT_EMPTY
    // until the watchdog flush aborts it.
    rst = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b110; read_enb = 3'b000;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      pkt_valid = (j == 27);
      step_model($sformatf("wdt%0d", j));
      check($sformatf("wdt%0d pulse", j),
            {7'd0, soft_reset[0]}, {7'd0, WDT && (j == 29)});
      if (j == 29)
        check("wdt abort pre", {7'd0, detect_add}, 8'd0);
      if (j == 30)
        check("wdt abort post", {7'd0, detect_add}, {7'd0, WDT});
    end

    rst = 1'b0;
    step_model("rst2");
    rst = 1'b1;
    for (int j = 1; j <= 52; j++) begin
      read_enb = (j == 20) ? 3'b001 : 3'b000;
      step_model($sformatf("rd%0d", j));
      check($sformatf("rd%0d pulse", j),
            {7'd0, soft_reset[0]}, {7'd0, WDT && (j == 49)});
    end
    read_enb = 3'b000;

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      pkt_valid = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom);
      for (int b = 0; b < 3; b++) begin
        fifo_full[b] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 29) == 0) fifo_empty[b] = ~fifo_empty[b];
        read_enb[b] = ($urandom_range(0, 39) == 0);
      end
      parity_done = ($urandom_range(0, 7) == 0);
      low_pkt_valid = ($urandom_range(0, 7) == 0);
      step_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_ctrl.md
# router_ctrl

Packet-ingress controller for the 1x3 router. Sits between the input interface (`pkt_valid`, `data_in`, `busy`) and the three output FIFOs plus the input register/parity block. Decodes the destination address from the header byte, sequences header/payload/parity loading through a Moore FSM, and raises `busy` for backpressure. Runs per-port idle-read watchdogs that soft-reset a FIFO whose data is not read.

## Interface
- `TIMEOUT`, 30: cycles a port may hold `vld_out` without `read_enb` before soft reset.
- `clk`  in  1  single system clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `pkt_valid`  in  1  packet framing from source; high from header through last payload byte.
- `data_in`  in  8  input byte; only `[1:0]` (destination address) is used, in DECODE.
- `fifo_full`  in  3  per-port FIFO full.
- `fifo_empty`  in  3  per-port FIFO empty.
- `read_enb`  in  3  per-port reader enable (watchdog input).
- `parity_done`  in  1  from register block: parity byte captured.
- `low_pkt_valid`  in  1  from register block: `pkt_valid` fell while FIFO was full.
- `busy`  out  1  backpressure to source.
- `write_enb`  out  3  one-hot FIFO write enable for latched port.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`  out  1 each  state strobes to register block.
- `vld_out`  out  3  `~fifo_empty`.
- `soft_reset`  out  3  one-cycle FIFO flush pulse per port.

## Operation
- States: DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, FIFO_FULL, LOAD_AFTER_FULL, CHECK_PARITY.
- DECODE: if `pkt_valid` and `data_in[1:0]!=2'b11`: latch `addr_q`; next LOAD_FIRST if `fifo_empty[addr]`, else WAIT_EMPTY. Address 3 or no `pkt_valid`: stay, byte dropped.
- WAIT_EMPTY -> LOAD_FIRST when `fifo_empty[addr_q]`.
- LOAD_FIRST -> LOAD_DATA unconditionally.
- LOAD_DATA: `fifo_full[addr_q]` -> FIFO_FULL (priority); else `!pkt_valid` -> LOAD_PARITY; else stay.
- LOAD_PARITY -> CHECK_PARITY.
- CHECK_PARITY: `fifo_full[addr_q]` -> FIFO_FULL; else DECODE.
- FIFO_FULL -> LOAD_AFTER_FULL when `!fifo_full[addr_q]`.
- LOAD_AFTER_FULL: `parity_done` -> DECODE; else `low_pkt_valid` -> LOAD_PARITY; else LOAD_DATA.
- `soft_reset[addr_q]` in any non-DECODE state forces DECODE next cycle (overrides all).
- Moore outputs from state only: `detect_add`=DECODE; `lfd_state`=LOAD_FIRST; `ld_state`=LOAD_DATA; `full_state`=FIFO_FULL; `laf_state`=LOAD_AFTER_FULL; `rst_int_reg`=CHECK_PARITY.
- `busy`=1 in all states except DECODE and LOAD_DATA.
- `write_enb` = one-hot(`addr_q`) in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; else 0.
- Watchdog per port i: counter increments while `vld_out[i] && !read_enb[i]`. Clears on `read_enb[i]` or `fifo_empty[i]`. At `TIMEOUT-1`: `soft_reset[i]`=1 for one cycle, counter clears.

## Timing
- Reset (`rst`=0 at posedge): state DECODE, `addr_q`=0, counters 0. Outputs: `detect_add`=1, `busy`=0, `write_enb`=0, `soft_reset`=0, other strobes 0; `vld_out` follows `fifo_empty`.
- Reset mid-packet aborts to DECODE at the next edge; no partial-write cleanup.
- Header at edge N into empty target: LOAD_FIRST (busy=1) at N+1, LOAD_DATA at N+2.
- `pkt_valid` low in LOAD_DATA at edge M: LOAD_PARITY at M+1, CHECK_PARITY at M+2, DECODE at M+3 if not full.
- `fifo_full` and `!pkt_valid` simultaneously in LOAD_DATA: FIFO_FULL wins.
- Watchdog: continuous unread valid data from edge K gives `soft_reset` high during cycle K+TIMEOUT-1.
- Counter width: `$clog2(TIMEOUT)` bits, no wrap beyond TIMEOUT-1.

## Configuration
- `ROUTER_SOFT_RESET_EN` defined: watchdogs present as above.
- Undefined: no counters, `soft_reset` tied 3'b000, soft-reset abort path absent; FSM otherwise identical.

## Structure
- `router_pkg`: `state_t` enum, `NUM_PORTS=3`, `ADDR_INVALID=2'b11`, `DEF_TIMEOUT=30`.
- Sub-module `router_soft_rst_timer`: one port's watchdog, instantiated 3x under the macro.

## Test plan
- Reset then header `data_in=8'h01`, `pkt_valid=1`, port 1 empty -> LOAD_FIRST next cycle, `busy`=1, then LOAD_DATA with `write_enb=3'b010`.
- Header addr 2, `fifo_empty[2]=0` -> WAIT_EMPTY, `busy`=1; release empty -> LOAD_FIRST next cycle.
- Header `8'h03` -> stays DECODE, `busy`=0, `write_enb`=0.
- `fifo_full[0]` in LOAD_DATA -> FIFO_FULL, `write_enb`=0; deassert full with `low_pkt_valid=1` -> LOAD_AFTER_FULL then LOAD_PARITY.
- Port 0 non-empty, `read_enb[0]`=0 for 30 cycles -> `soft_reset[0]` pulses on cycle 30; mid-packet on port 0 -> DECODE next cycle.
- `read_enb[0]` pulsed at cycle 20 -> counter clears, no `soft_reset` before cycle 50.
